// File: rtl/apb_reg_bridge.sv
// APB3 completer driving the single-cycle register bus (reg_wr/reg_rd) of the *_reg blocks.
// Every output is a flop; reads return reg_rdat captured one cycle after the reg_rd strobe.
module apb_reg_bridge #(
  parameter int ADDR_WIDTH  = 24,
  parameter int PADDR_WIDTH = 32
) (
  input  logic                   reg_clk,
  input  logic                   reg_rstn,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [PADDR_WIDTH-1:0] paddr,
  input  logic [31:0]            pwdata,
  input  logic [3:0]             pstrb,
  output logic                   pready,
  output logic [31:0]            prdata,
  output logic                   pslverr,
  output logic                   reg_wr,
  output logic                   reg_rd,
  output logic [3:0]             reg_we,
  output logic [ADDR_WIDTH-1:0]  reg_addr,
  output logic [31:0]            reg_wdat,
  input  logic [31:0]            reg_rdat,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RWAIT, S_ACK} state_t;

  state_t                r_state;
  logic                  r_write;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [31:0]           r_prdata;
  logic                  r_wr;
  logic                  r_rd;
  logic [3:0]            r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdat;
  logic                  r_busy;

  logic w_hi_err;
  logic w_addr_err;
  logic w_setup;

  // Upper-bit check only exists when the APB address is wider than the register bus.
  generate
    if (PADDR_WIDTH > ADDR_WIDTH) begin : g_hi
      assign w_hi_err = |paddr[PADDR_WIDTH-1:ADDR_WIDTH];
    end else begin : g_nohi
      assign w_hi_err = 1'b0;
    end
  endgenerate

  assign w_addr_err = (|paddr[1:0]) | w_hi_err;
  assign w_setup    = psel & ~penable;

  always_ff @(posedge reg_clk or negedge reg_rstn) begin
    if (!reg_rstn) begin
      r_state   <= S_IDLE;
      r_write   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_we      <= '0;
      r_addr    <= '0;
      r_wdat    <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_we      <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_write <= pwrite;
            r_busy  <= 1'b1;
            if (w_addr_err) begin
              r_state   <= S_ACK;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_prdata  <= '0;
            end else begin
              r_state <= S_CMD;
              r_addr  <= paddr[ADDR_WIDTH-1:0];
              if (pwrite) begin
                // All-zero strobes complete normally but never pulse reg_wr.
                r_wdat <= pwdata;
                r_we   <= pstrb;
                r_wr   <= |pstrb;
              end else begin
                r_rd <= 1'b1;
              end
            end
          end
        end
        S_CMD: begin
          if (!psel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_write) begin
            r_state  <= S_ACK;
            r_pready <= 1'b1;
            r_prdata <= '0;
          end else begin
            r_state <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (!psel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state  <= S_ACK;
            r_pready <= 1'b1;
            r_prdata <= reg_rdat;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pready   = r_pready;
  assign pslverr  = r_pslverr;
  assign prdata   = r_prdata;
  assign reg_wr   = r_wr;
  assign reg_rd   = r_rd;
  assign reg_we   = r_we;
  assign reg_addr = r_addr;
  assign reg_wdat = r_wdat;
  assign busy     = r_busy;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed bench for apb_reg_bridge: hand-computed expectations, register-block read model.
module tb_apb_reg_bridge;
  logic        reg_clk = 1'b0;
  logic        reg_rstn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr, reg_wr, reg_rd, busy;
  logic [31:0] prdata, reg_wdat;
  logic [3:0]  reg_we;
  logic [23:0] reg_addr;
  logic [31:0] reg_rdat = '0;
  logic [31:0] rd_val = '0;

  int n_cmp = 0, n_err = 0;
  int n_wr = 0, n_rd = 0, n_rdy = 0;
  int s_wr, s_rd, s_rdy;

  apb_reg_bridge #(.ADDR_WIDTH(24), .PADDR_WIDTH(32)) dut (
    .reg_clk(reg_clk), .reg_rstn(reg_rstn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdat(reg_wdat),
    .reg_rdat(reg_rdat), .busy(busy)
  );

  always #5 reg_clk = ~reg_clk;

  // Register block model: registered read data the cycle after reg_rd.
  always @(posedge reg_clk) if (reg_rd) reg_rdat <= rd_val;

  always @(posedge reg_clk) begin
    if (reg_wr) n_wr++;
    if (reg_rd) n_rd++;
    if (pready) n_rdy++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge reg_clk); #1;
  endtask

  task automatic setup(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic snap();
    s_wr = n_wr; s_rd = n_rd; s_rdy = n_rdy;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_pready", pready, 0);   chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", pslverr, 0); chk("rst_reg_wr", reg_wr, 0);
    chk("rst_reg_rd", reg_rd, 0);   chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_addr", reg_addr, 0); chk("rst_reg_wdat", reg_wdat, 0);
    chk("rst_busy", busy, 0);
    reg_rstn = 1'b1;
    tick();

    // Write 0x8
    setup(1, 32'h8, 32'h0000_1E02, 4'b0011);
    tick();
    chk("wr_T1_reg_wr", reg_wr, 1);     chk("wr_T1_addr", reg_addr, 32'h8);
    chk("wr_T1_we", reg_we, 4'b0011);   chk("wr_T1_wdat", reg_wdat, 32'h1E02);
    chk("wr_T1_pready", pready, 0);     chk("wr_T1_busy", busy, 1);
    penable = 1'b1;
    tick();
    chk("wr_T2_pready", pready, 1);     chk("wr_T2_pslverr", pslverr, 0);
    chk("wr_T2_reg_wr", reg_wr, 0);     chk("wr_T2_we", reg_we, 0);
    chk("wr_T2_prdata", prdata, 0);
    bus_idle();
    tick();
    chk("wr_T3_pready", pready, 0);     chk("wr_T3_busy", busy, 0);
    chk("wr_hold_wdat", reg_wdat, 32'h1E02);

    // Read 0x0
    rd_val = 32'h0000_0100;
    setup(0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("rd_T1_reg_rd", reg_rd, 1);     chk("rd_T1_addr", reg_addr, 0);
    chk("rd_T1_pready", pready, 0);
    penable = 1'b1;
    tick();
    chk("rd_T2_reg_rd", reg_rd, 0);     chk("rd_T2_pready", pready, 0);
    tick();
    chk("rd_T3_pready", pready, 1);     chk("rd_T3_prdata", prdata, 32'h100);
    chk("rd_T3_pslverr", pslverr, 0);
    bus_idle();
    tick();
    chk("rd_T4_pready", pready, 0);     chk("rd_hold_prdata", prdata, 32'h100);

    // Misaligned read and write, then out-of-range write
    snap();
    setup(0, 32'h6, 32'h0, 4'h0);
    tick();
    chk("mis_rd_pready", pready, 1);    chk("mis_rd_pslverr", pslverr, 1);
    chk("mis_rd_prdata", prdata, 0);
    penable = 1'b1; tick(); bus_idle();
    chk("mis_rd_after_pslverr", pslverr, 0);
    tick();
    setup(1, 32'h6, 32'hDEAD_BEEF, 4'hF);
    tick();
    chk("mis_wr_pready", pready, 1);    chk("mis_wr_pslverr", pslverr, 1);
    chk("mis_wr_prdata", prdata, 0);
    penable = 1'b1; tick(); bus_idle(); tick();
    setup(1, 32'h0100_0000, 32'h1111_2222, 4'hF);
    tick();
    chk("oor_pready", pready, 1);       chk("oor_pslverr", pslverr, 1);
    penable = 1'b1; tick(); bus_idle(); tick();
    chk("err_no_wr", n_wr - s_wr, 0);   chk("err_no_rd", n_rd - s_rd, 0);
    chk("err_addr_held", reg_addr, 0);  chk("err_wdat_held", reg_wdat, 32'h1E02);

    // Back-to-back write then read, psel held high
    snap();
    rd_val = 32'hCAFE_F00D;
    setup(1, 32'h10, 32'hA5A5_0001, 4'hF);
    tick();
    chk("b2b_wr_T1", reg_wr, 1);
    penable = 1'b1;
    tick();
    chk("b2b_wr_T2_pready", pready, 1);
    setup(0, 32'h10, 32'h0, 4'h0);
    tick();
    chk("b2b_rd_T0_pready", pready, 0);
    tick();
    chk("b2b_rd_T1", reg_rd, 1);        chk("b2b_rd_addr", reg_addr, 32'h10);
    penable = 1'b1;
    tick();
    chk("b2b_rd_T2_pready", pready, 0);
    tick();
    chk("b2b_rd_T3_pready", pready, 1); chk("b2b_rd_prdata", prdata, 32'hCAFE_F00D);
    bus_idle();
    tick();
    chk("b2b_wr_count", n_wr - s_wr, 1); chk("b2b_rd_count", n_rd - s_rd, 1);
    chk("b2b_rdy_count", n_rdy - s_rdy, 2);

    // Reset in RWAIT, then a normal read
    rd_val = 32'h0000_1234;
    setup(0, 32'h4, 32'h0, 4'h0);
    tick(); penable = 1'b1;
    tick();
    chk("rw_busy", busy, 1);
    snap();
    #2 reg_rstn = 1'b0;
    #1;
    chk("arst_pready", pready, 0);      chk("arst_busy", busy, 0);
    chk("arst_prdata", prdata, 0);      chk("arst_addr", reg_addr, 0);
    chk("arst_wdat", reg_wdat, 0);
    bus_idle();
    tick(); tick();
    chk("arst_no_pready", n_rdy - s_rdy, 0);
    reg_rstn = 1'b1;
    tick();
    setup(0, 32'h4, 32'h0, 4'h0);
    tick(); chk("post_rst_reg_rd", reg_rd, 1); penable = 1'b1;
    tick(); tick();
    chk("post_rst_pready", pready, 1);  chk("post_rst_prdata", prdata, 32'h1234);
    bus_idle(); tick();

    // Write with all strobes clear
    snap();
    setup(1, 32'hC, 32'h5555_AAAA, 4'h0);
    tick();
    chk("s0_T1_reg_wr", reg_wr, 0);     chk("s0_T1_we", reg_we, 0);
    chk("s0_T1_busy", busy, 1);
    penable = 1'b1;
    tick();
    chk("s0_T2_pready", pready, 1);     chk("s0_T2_pslverr", pslverr, 0);
    bus_idle(); tick();
    chk("s0_no_wr", n_wr - s_wr, 0);

    // penable without setup in IDLE is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h20;
    tick();
    chk("ign_busy", busy, 0);           chk("ign_reg_rd", reg_rd, 0);
    bus_idle(); tick();

    // psel dropped in CMD aborts without pready
    snap();
    setup(0, 32'h20, 32'h0, 4'h0);
    tick();
    chk("abort_reg_rd", reg_rd, 1);
    bus_idle();
    tick();
    chk("abort_busy", busy, 0);
    tick(); tick();
    chk("abort_no_pready", n_rdy - s_rdy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/apb_reg_bridge.md
Name: apb_reg_bridge

Overview:
APB3 completer that converts APB transfers into the single-cycle register-bus commands (reg_wr / reg_rd / reg_we / reg_addr / reg_wdat) consumed by the generated *_reg register blocks. It captures their registered reg_rdat one cycle after reg_rd and returns it on prdata. One bridge sits between the SoC APB fabric and a bank of register blocks that share one decoded register bus.

Parameters:
ADDR_WIDTH, 24, width of reg_addr; must match the ADDR_WIDTH of the downstream register blocks
PADDR_WIDTH, 32, width of the APB paddr; must be >= ADDR_WIDTH

Ports:
reg_clk  in  1  clock; all logic on the rising edge
reg_rstn  in  1  asynchronous, active-low reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1 = write, 0 = read
paddr  in  PADDR_WIDTH  APB byte address
pwdata  in  32  APB write data
pstrb  in  4  APB byte strobes
pready  out  1  transfer complete
prdata  out  32  read data, valid when pready=1 and pwrite=0
pslverr  out  1  error response, valid only with pready
reg_wr  out  1  one-cycle write strobe to register blocks
reg_rd  out  1  one-cycle read strobe to register blocks
reg_we  out  4  byte enables; nonzero only while reg_wr=1
reg_addr  out  ADDR_WIDTH  register address
reg_wdat  out  32  register write data
reg_rdat  in  32  registered read data from register blocks, valid the cycle after reg_rd
busy  out  1  1 when the FSM is not in IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset asserted mid-transfer aborts the transfer immediately with no pready; any command already issued is not retracted.
- All outputs are registered. No combinational path from APB inputs to any output.
- FSM states: IDLE, CMD, RWAIT, ACK.
- IDLE: on setup phase (psel=1, penable=0), the bridge registers paddr, pwrite, pwdata and pstrb.
  - Address error: paddr[1:0] != 0, or paddr[PADDR_WIDTH-1:ADDR_WIDTH] != 0. Go to ACK with pslverr=1 and pready=1 on the next cycle. No reg_wr or reg_rd is issued.
  - Otherwise go to CMD. reg_addr = paddr[ADDR_WIDTH-1:0].
    - Write: reg_wr=1, reg_we=pstrb, reg_wdat=pwdata, each for exactly one cycle. If pstrb=0, reg_wr stays 0 (suppressed write) and the transfer still completes normally.
    - Read: reg_rd=1 for exactly one cycle.
- CMD: reg_wr, reg_rd and reg_we return to 0.
  - Write: go to ACK with pready=1 and pslverr=0.
  - Read: go to RWAIT.
- RWAIT: prdata <= reg_rdat. Then go to ACK with pready=1.
- ACK: pready is high for exactly one cycle, then the FSM returns to IDLE unconditionally. The next setup phase can be accepted in the IDLE cycle that follows.
- Latency from setup cycle T0:
  - Write: reg_wr high in T1, pready in T2.
  - Read: reg_rd high in T1, reg_rdat sampled at end of T2, pready with prdata in T3.
  - Error: pready with pslverr in T1.
- prdata:
  - Holds its value until the next read completes.
  - Is 0 on write responses.
  - Is 0 on error responses.
- pslverr is 0 whenever pready=0.
- reg_addr and reg_wdat hold their last values between transfers.
- Protocol violation: if psel drops in CMD or RWAIT, return to IDLE at the next edge with no pready. penable=1 seen in IDLE without a prior setup phase is ignored.
- busy = (state != IDLE), registered.

Test Plan:
- Write paddr=0x000008, pwdata=0x0000_1E02, pstrb=4'b0011 -> reg_wr=1 for one cycle in T1 with reg_addr=0x8, reg_we=0011, reg_wdat=0x1E02; pready=1, pslverr=0 in T2 only.
- Read paddr=0x000000 with the model returning reg_rdat=0x0000_0100 in the cycle after reg_rd -> reg_rd is a one-cycle pulse in T1; pready=1 and prdata=0x100 in T3.
- Misaligned paddr=0x000006 (read and write) -> pready=1, pslverr=1 in T1; reg_wr and reg_rd never assert; prdata=0.
- Out-of-range paddr=0x0100_0000 with ADDR_WIDTH=24 -> pslverr=1 response; no register command issued.
- Back-to-back write then read with psel held high -> two correct transfers, 3 and 4 cycles long; exactly one reg_wr pulse followed by exactly one reg_rd pulse.
- reg_rstn asserted in RWAIT -> all outputs 0 asynchronously; no pready; the next read after reset completes normally.
- Write with pstrb=0 -> no reg_wr pulse; pready=1, pslverr=0 in T2.
